matrix_scan_driver: RTL and testbench

- Downstream display stage of the snake game. Owns a double-buffered 8x8 RGB frame store and drives the time-multiplexed LED matrix pins (SEL, DATA_R/G/B).
- The game logic writes rows into the back buffer and requests a swap. The swap takes effect only at a frame boundary, so a half-updated board is never shown.
- Each row slot begins with a blanking interval to suppress ghosting.

---
 rtl/matrix_pkg.sv | 26 ++
 rtl/row_timer.sv | 62 ++++++
 rtl/matrix_scan_driver.sv | 153 +++++++++++++++
 tb/tb_matrix_scan_driver.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// matrix_pkg: shared types and constants for the 8x8 RGB LED matrix display
// stage. Holds the row/frame storage types, the "all LEDs off" row value,
// the SEL base pattern (enable bit set, row 0), and the swap FSM state type.
`timescale 1ns/1ps
package matrix_pkg;

  // One row of one colour plane; active-low, 0 = LED on.
  typedef logic [7:0] row_t;

  // One colour plane of a full frame, indexed by row.
  typedef row_t [7:0] frame_t;

  localparam row_t       ROW_OFF  = 8'hFF;
  localparam logic [3:0] SEL_BASE = 4'b1000;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } swap_state_t;

  // A colour plane with every LED dark.
  function automatic frame_t frame_off();
    return {8{ROW_OFF}};
  endfunction

endpackage

// File: rtl/row_timer.sv
// row_timer: slot timing for the multiplexed LED matrix.
// Ports:
//   clk_i            system clock
//   rst_ni           asynchronous active-low reset
//   row_o            row currently being scanned (0..7)
//   blank_o          high while the slot is in its blanking interval
//   slot_start_o     high in the first counter cycle of every row slot
//   frame_boundary_o high in the first counter cycle of the row 0 slot
// All outputs are decoded from the counter registers; the consumer
// registers them, which gives the one-cycle output latency.
`timescale 1ns/1ps
module row_timer #(
  parameter int ROW_CYCLES   = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic [2:0] row_o,
  output logic       blank_o,
  output logic       slot_start_o,
  output logic       frame_boundary_o
);

  localparam int            CW    = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
  localparam logic [CW-1:0] LAST  = CW'(ROW_CYCLES - 1);
  localparam logic [CW-1:0] BLANK = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [2:0]    row_q;
  logic [2:0]    row_d;

  // Next-state for the cycle counter and the row counter it carries into.
  always_comb begin
    cnt_d = cnt_q;
    row_d = row_q;
    if (cnt_q == LAST) begin
      cnt_d = '0;
      row_d = row_q + 3'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
      row_d = row_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      row_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
      row_q <= row_d;
    end
  end

  assign row_o            = row_q;
  assign blank_o          = (cnt_q < BLANK);
  assign slot_start_o     = (cnt_q == '0);
  assign frame_boundary_o = (cnt_q == '0) && (row_q == 3'd0);

endmodule

// File: rtl/matrix_scan_driver.sv
// matrix_scan_driver: double-buffered 8x8 RGB frame store driving a
// time-multiplexed LED matrix.
// Ports:
//   CLK, RST_N              clock, asynchronous active-low reset
//   wr_en, wr_row           write one back-buffer row this cycle
//   wr_r, wr_g, wr_b        row data, active-low
//   swap_req                one-cycle request to exchange back/front buffers
//   swap_ack                one-cycle pulse when the exchange takes effect
//   frame_start             one-cycle pulse at the start of the row 0 slot
//   SEL                     {enable=1, row[2:0]}
//   DATA_R, DATA_G, DATA_B  column drive, active-low
// The swap only happens at the row 7 -> row 0 boundary so a frame is never
// shown half-updated. All pin outputs are registered.
`timescale 1ns/1ps
module matrix_scan_driver
  import matrix_pkg::*;
#(
  parameter int ROW_CYCLES   = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_r,
  input  logic [7:0] wr_g,
  input  logic [7:0] wr_b,
  input  logic       swap_req,
  output logic       swap_ack,
  output logic       frame_start,
  output logic [3:0] SEL,
  output logic [7:0] DATA_R,
  output logic [7:0] DATA_G,
  output logic [7:0] DATA_B
);

  logic [2:0] row_s;
  logic       blank_s;
  logic       slot_start_s;
  logic       frame_boundary_s;

  row_timer #(
    .ROW_CYCLES  (ROW_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_row_timer (
    .clk_i           (CLK),
    .rst_ni          (RST_N),
    .row_o           (row_s),
    .blank_o         (blank_s),
    .slot_start_o    (slot_start_s),
    .frame_boundary_o(frame_boundary_s)
  );

  // Two frame buffers per colour; front_sel_q picks the displayed one.
  frame_t      buf_r_q [2];
  frame_t      buf_g_q [2];
  frame_t      buf_b_q [2];
  logic        front_sel_q;
  logic        back_sel_s;
  swap_state_t state_q;
  logic        swap_ack_q;
  logic        frame_start_q;
  logic [3:0]  sel_q;
  row_t        data_r_q;
  row_t        data_g_q;
  row_t        data_b_q;

  assign back_sel_s = ~front_sel_q;

  // Swap FSM. A request arriving on the boundary cycle itself swaps at
  // once; requests while already pending collapse into that one swap.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      front_sel_q <= 1'b0;
      swap_ack_q  <= 1'b0;
    end else begin
      swap_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (swap_req && frame_boundary_s) begin
            front_sel_q <= ~front_sel_q;
            swap_ack_q  <= 1'b1;
          end else if (swap_req) begin
            state_q <= PENDING;
          end else begin
            state_q <= IDLE;
          end
        end
        PENDING: begin
          if (frame_boundary_s) begin
            front_sel_q <= ~front_sel_q;
            swap_ack_q  <= 1'b1;
            state_q     <= IDLE;
          end else begin
            state_q <= PENDING;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Back-buffer writes. The target is chosen from the pre-edge select, so a
  // write in the swap cycle lands in the buffer that becomes the new front.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      buf_r_q[0] <= frame_off();
      buf_r_q[1] <= frame_off();
      buf_g_q[0] <= frame_off();
      buf_g_q[1] <= frame_off();
      buf_b_q[0] <= frame_off();
      buf_b_q[1] <= frame_off();
    end else if (wr_en) begin
      buf_r_q[back_sel_s][wr_row] <= wr_r;
      buf_g_q[back_sel_s][wr_row] <= wr_g;
      buf_b_q[back_sel_s][wr_row] <= wr_b;
    end
  end

  // Registered pin drive: row select, blanked column data, frame marker.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sel_q         <= SEL_BASE;
      data_r_q      <= ROW_OFF;
      data_g_q      <= ROW_OFF;
      data_b_q      <= ROW_OFF;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= frame_boundary_s;
      if (slot_start_s) begin
        sel_q <= SEL_BASE | {1'b0, row_s};
      end
      if (blank_s) begin
        data_r_q <= ROW_OFF;
        data_g_q <= ROW_OFF;
        data_b_q <= ROW_OFF;
      end else begin
        data_r_q <= buf_r_q[front_sel_q][row_s];
        data_g_q <= buf_g_q[front_sel_q][row_s];
        data_b_q <= buf_b_q[front_sel_q][row_s];
      end
    end
  end

  assign swap_ack    = swap_ack_q;
  assign frame_start = frame_start_q;
  assign SEL         = sel_q;
  assign DATA_R      = data_r_q;
  assign DATA_G      = data_g_q;
  assign DATA_B      = data_b_q;

endmodule

// File: tb/tb_matrix_scan_driver.sv
`timescale 1ns/1ps
module tb_matrix_scan_driver;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Small instance (ROW_CYCLES=10, BLANK_CYCLES=2)
  logic       RST_N;
  logic       wr_en, swap_req;
  logic [2:0] wr_row;
  logic [7:0] wr_r, wr_g, wr_b;
  logic       swap_ack, frame_start;
  logic [3:0] SEL;
  logic [7:0] DATA_R, DATA_G, DATA_B;

  // Default-parameter instance
  logic       d_rst_n;
  logic       d_wr_en, d_swap_req;
  logic [2:0] d_wr_row;
  logic [7:0] d_wr_r, d_wr_g, d_wr_b;
  logic       d_swap_ack, d_frame_start;
  logic [3:0] d_SEL;
  logic [7:0] d_DATA_R, d_DATA_G, d_DATA_B;

  matrix_scan_driver #(.ROW_CYCLES(10), .BLANK_CYCLES(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .wr_en(wr_en), .wr_row(wr_row),
    .wr_r(wr_r), .wr_g(wr_g), .wr_b(wr_b), .swap_req(swap_req),
    .swap_ack(swap_ack), .frame_start(frame_start), .SEL(SEL),
    .DATA_R(DATA_R), .DATA_G(DATA_G), .DATA_B(DATA_B)
  );

  matrix_scan_driver dut_def (
    .CLK(CLK), .RST_N(d_rst_n), .wr_en(d_wr_en), .wr_row(d_wr_row),
    .wr_r(d_wr_r), .wr_g(d_wr_g), .wr_b(d_wr_b), .swap_req(d_swap_req),
    .swap_ack(d_swap_ack), .frame_start(d_frame_start), .SEL(d_SEL),
    .DATA_R(d_DATA_R), .DATA_G(d_DATA_G), .DATA_B(d_DATA_B)
  );

  int tests  = 0;
  int failed = 0;

  // Reference model of the small instance
  int         e;       // clock edges since reset release
  int         n_ack;   // swap_ack pulses observed
  logic [7:0] mr [2][8];
  logic [7:0] mg [2][8];
  logic [7:0] mb [2][8];
  int         mfront;
  bit         mpend;
  logic [29:0] expq [$];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 8; j++) begin
        mr[i][j] = 8'hFF; mg[i][j] = 8'hFF; mb[i][j] = 8'hFF;
      end
    end
    mfront = 0;
    mpend  = 1'b0;
    e      = 0;
    expq.delete();
  endtask

  // Predict the outputs of the coming edge from the current inputs, push to
  // the scoreboard, clock, then pop and compare.
  task automatic step();
    int cnt, row;
    bit bnd, fire;
    logic [7:0] er, eg, eb;
    logic [29:0] ex, got;
    cnt  = e % 10;
    row  = (e / 10) % 8;
    bnd  = (cnt == 0) && (row == 0);
    fire = bnd && (mpend || (swap_req === 1'b1));
    if (cnt < 2) begin
      er = 8'hFF; eg = 8'hFF; eb = 8'hFF;
    end else begin
      er = mr[mfront][row]; eg = mg[mfront][row]; eb = mb[mfront][row];
    end
    expq.push_back({fire, bnd, 1'b1, 3'(row), er, eg, eb});
    if (wr_en === 1'b1) begin
      mr[1-mfront][wr_row] = wr_r;
      mg[1-mfront][wr_row] = wr_g;
      mb[1-mfront][wr_row] = wr_b;
    end
    if (fire) begin
      mfront = 1 - mfront;
      mpend  = 1'b0;
    end else if (swap_req === 1'b1) begin
      mpend = 1'b1;
    end
    e++;
    @(posedge CLK); #1;
    got = {swap_ack, frame_start, SEL, DATA_R, DATA_G, DATA_B};
    ex  = expq.pop_front();
    tests++;
    if (got !== ex) begin
      failed++;
      $display("FAIL scan edge=%0d got{ack,fs,sel,r,g,b}=%h expected=%h", e - 1, got, ex);
    end
    if (swap_ack === 1'b1) n_ack++;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; d_rst_n = 1'b0;
    wr_en = 1'b0; swap_req = 1'b0; wr_row = 3'd0;
    wr_r = 8'hFF; wr_g = 8'hFF; wr_b = 8'hFF;
    d_wr_en = 1'b0; d_swap_req = 1'b0; d_wr_row = 3'd0;
    d_wr_r = 8'hFF; d_wr_g = 8'hFF; d_wr_b = 8'hFF;
    n_ack = 0;
    repeat (3) @(posedge CLK);
    #1;
    tests++; if (SEL !== 4'b1000) begin failed++; $display("FAIL reset_sel got=%b expected=1000", SEL); end
    tests++; if ({DATA_R, DATA_G, DATA_B} !== 24'hFFFFFF) begin failed++; $display("FAIL reset_data got=%h expected=ffffff", {DATA_R, DATA_G, DATA_B}); end
    tests++; if (swap_ack !== 1'b0) begin failed++; $display("FAIL reset_ack got=%b expected=0", swap_ack); end
    tests++; if (frame_start !== 1'b0) begin failed++; $display("FAIL reset_fs got=%b expected=0", frame_start); end
    @(negedge CLK);
    RST_N = 1'b1;
    model_reset();
  endtask

  task automatic test_idle_scan();
    int fs_cnt, fs_first, fs_second;
    fs_cnt = 0; fs_first = -1; fs_second = -1;
    for (int s = 0; s < 100; s++) begin
      step();
      if (frame_start === 1'b1) begin
        if (fs_cnt == 0) fs_first = s; else if (fs_cnt == 1) fs_second = s;
        fs_cnt++;
      end
    end
    tests++; if (fs_cnt != 2) begin failed++; $display("FAIL idle_fs_count got=%0d expected=2", fs_cnt); end
    tests++; if (fs_second - fs_first != 80) begin failed++; $display("FAIL idle_fs_period got=%0d expected=80", fs_second - fs_first); end
  endtask

  task automatic test_write_swap();
    bit found;
    int n3, other_bad;
    logic [7:0] g3 [10];
    wr_en = 1'b1; wr_row = 3'd3; wr_r = 8'hFF; wr_g = 8'h0F; wr_b = 8'hFF;
    step();
    wr_en = 1'b0; swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (swap_ack === 1'b1) found = 1'b1;
    end
    tests++; if (!found) begin failed++; $display("FAIL swap_ack_timeout got=none expected=pulse within 200 cycles"); end
    tests++; if (frame_start !== 1'b1) begin failed++; $display("FAIL swap_ack_with_fs got fs=%b expected=1", frame_start); end
    n3 = 0; other_bad = 0;
    for (int i = 0; i < 79; i++) begin
      step();
      if (SEL === 4'b1011) begin
        if (n3 < 10) g3[n3] = DATA_G;
        n3++;
      end else if (DATA_G !== 8'hFF) begin
        other_bad++;
      end
    end
    tests++; if (n3 != 10) begin failed++; $display("FAIL row3_slot_len got=%0d expected=10", n3); end
    for (int i = 0; i < 10 && i < n3; i++) begin
      tests++;
      if (g3[i] !== ((i < 2) ? 8'hFF : 8'h0F)) begin
        failed++;
        $display("FAIL row3_g[%0d] got=%h expected=%h", i, g3[i], (i < 2) ? 8'hFF : 8'h0F);
      end
    end
    tests++; if (other_bad != 0) begin failed++; $display("FAIL other_rows_g got=%0d lit samples expected=0", other_bad); end
  endtask

  task automatic test_double_swap();
    int a0, lit;
    while ((e % 80) / 10 != 2) step();
    swap_req = 1'b1; step(); swap_req = 1'b0;
    while ((e % 80) / 10 != 5) step();
    swap_req = 1'b1; step(); swap_req = 1'b0;
    a0 = n_ack;
    while (e % 80 != 0) step();
    step();
    tests++; if (swap_ack !== 1'b1) begin failed++; $display("FAIL dbl_ack_at_boundary got=%b expected=1", swap_ack); end
    lit = 0;
    for (int i = 0; i < 79; i++) begin
      step();
      if (DATA_G !== 8'hFF) lit++;
    end
    tests++; if (n_ack - a0 != 1) begin failed++; $display("FAIL dbl_ack_count got=%0d expected=1", n_ack - a0); end
    tests++; if (lit != 0) begin failed++; $display("FAIL dbl_front_toggle got=%0d lit G samples expected=0", lit); end
  endtask

  task automatic test_boundary_swap_write();
    logic [7:0] rv [9];
    while (e % 80 != 0) step();
    swap_req = 1'b1; wr_en = 1'b1; wr_row = 3'd0;
    wr_r = 8'h00; wr_g = 8'hFF; wr_b = 8'hFF;
    step();
    swap_req = 1'b0; wr_en = 1'b0;
    tests++; if (swap_ack !== 1'b1) begin failed++; $display("FAIL bnd_ack got=%b expected=1", swap_ack); end
    tests++; if (frame_start !== 1'b1) begin failed++; $display("FAIL bnd_fs got=%b expected=1", frame_start); end
    tests++; if (DATA_R !== 8'hFF) begin failed++; $display("FAIL bnd_blank0 got=%h expected=ff", DATA_R); end
    for (int i = 0; i < 9; i++) begin
      step();
      rv[i] = DATA_R;
    end
    for (int i = 0; i < 9; i++) begin
      tests++;
      if (rv[i] !== ((i < 1) ? 8'hFF : 8'h00)) begin
        failed++;
        $display("FAIL bnd_row0_r[%0d] got=%h expected=%h", i + 1, rv[i], (i < 1) ? 8'hFF : 8'h00);
      end
    end
  endtask

  task automatic test_reset_mid();
    int a0, lit;
    while (!(((e % 80) / 10 == 4) && (e % 10 == 3))) step();
    swap_req = 1'b1; step(); swap_req = 1'b0;
    step();
    #2;
    RST_N = 1'b0;
    #1;
    tests++; if (SEL !== 4'b1000) begin failed++; $display("FAIL midrst_sel got=%b expected=1000", SEL); end
    tests++; if ({DATA_R, DATA_G, DATA_B} !== 24'hFFFFFF) begin failed++; $display("FAIL midrst_data got=%h expected=ffffff", {DATA_R, DATA_G, DATA_B}); end
    tests++; if ({swap_ack, frame_start} !== 2'b00) begin failed++; $display("FAIL midrst_pulses got=%b expected=00", {swap_ack, frame_start}); end
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    model_reset();
    a0 = n_ack; lit = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if ({DATA_R, DATA_G, DATA_B} !== 24'hFFFFFF) lit++;
    end
    tests++; if (n_ack - a0 != 0) begin failed++; $display("FAIL midrst_no_ack got=%0d expected=0", n_ack - a0); end
    tests++; if (lit != 0) begin failed++; $display("FAIL midrst_blank got=%0d lit samples expected=0", lit); end
  endtask

  task automatic test_defaults();
    int blank_len, slot_len;
    logic [7:0] first_r;
    @(negedge CLK);
    d_rst_n = 1'b1; d_swap_req = 1'b1; d_wr_en = 1'b1; d_wr_row = 3'd0;
    d_wr_r = 8'h00; d_wr_g = 8'hFF; d_wr_b = 8'hFF;
    @(posedge CLK); #1;
    d_swap_req = 1'b0; d_wr_en = 1'b0;
    tests++; if ({d_frame_start, d_swap_ack} !== 2'b11) begin failed++; $display("FAIL def_start got{fs,ack}=%b expected=11", {d_frame_start, d_swap_ack}); end
    tests++; if ({d_SEL, d_DATA_R, d_DATA_G, d_DATA_B} !== {4'b1000, 24'hFFFFFF}) begin failed++; $display("FAIL def_first got=%h expected=8ffffff", {d_SEL, d_DATA_R, d_DATA_G, d_DATA_B}); end
    blank_len = -1; slot_len = -1; first_r = 8'hFF;
    for (int t = 1; t <= 60000 && slot_len < 0; t++) begin
      @(posedge CLK); #1;
      if (blank_len < 0 && d_DATA_R !== 8'hFF) begin
        blank_len = t;
        first_r   = d_DATA_R;
      end
      if (d_SEL !== 4'b1000) slot_len = t;
    end
    tests++; if (blank_len != 500) begin failed++; $display("FAIL def_blank got=%0d expected=500", blank_len); end
    tests++; if (first_r !== 8'h00) begin failed++; $display("FAIL def_row0_r got=%h expected=00", first_r); end
    tests++; if (slot_len != 50000) begin failed++; $display("FAIL def_slot got=%0d expected=50000", slot_len); end
    tests++; if (d_SEL !== 4'b1001) begin failed++; $display("FAIL def_next_sel got=%b expected=1001", d_SEL); end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle_scan();
    test_write_swap();
    test_double_swap();
    test_boundary_swap_write();
    test_reset_mid();
    test_defaults();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
